// File: rtl/button_conditioner.sv
// Front-panel button receiver: synchroniser, tick-paced debouncer, press detector and auto-repeat.
// Auto-repeat step events are built only when BUTTON_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module button_conditioner #(
  parameter int                   N_BUTTONS      = 6,
  parameter int                   DEBOUNCE_COUNT = 4,
  parameter int                   REPEAT_DELAY   = 4096,
  parameter int                   REPEAT_PERIOD  = 1024,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK    = 6'b011110
) (
  input  logic                 clk_2M5,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_BUTTONS-1:0] buttons_n,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_step
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_COUNT);

  logic [N_BUTTONS-1:0] r_sync1;
  logic [N_BUTTONS-1:0] r_sync2;
  logic                 r_tickQ;
  logic [N_BUTTONS-1:0] r_level;
  logic [N_BUTTONS-1:0] r_press;
  logic [N_BUTTONS-1:0] w_rawPressed;
  logic [N_BUTTONS-1:0] w_toggle;
  logic                 w_tickRise;

  // Synchroniser and tick edge register come out of reset as "released" / "tick high"
  // so a reset never manufactures a press or a spurious tick edge.
  always_ff @(posedge clk_2M5) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_tickQ <= 1'b1;
    end else begin
      r_sync1 <= buttons_n;
      r_sync2 <= r_sync1;
      r_tickQ <= tick;
    end
  end

  assign w_rawPressed = ~r_sync2;
  assign w_tickRise   = tick & ~r_tickQ;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_debounce
    logic [3:0] r_dbCnt;
    logic [3:0] w_dbNext;

    assign w_dbNext     = r_dbCnt + 4'd1;
    assign w_toggle[gi] = w_tickRise && (w_rawPressed[gi] != r_level[gi]) && (w_dbNext == DB_TARGET);

    always_ff @(posedge clk_2M5) begin
      if (rst) begin
        r_dbCnt <= '0;
      end else if (w_tickRise) begin
        if ((w_rawPressed[gi] == r_level[gi]) || w_toggle[gi]) begin
          r_dbCnt <= '0;
        end else begin
          r_dbCnt <= w_dbNext;
        end
      end
    end
  end

  // Press pulse is registered alongside the level so both rise on the same edge.
  always_ff @(posedge clk_2M5) begin
    if (rst) begin
      r_level <= '0;
      r_press <= '0;
    end else begin
      r_level <= r_level ^ w_toggle;
      r_press <= w_toggle & ~r_level;
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [15:0] DELAY_LOAD  = 16'(REPEAT_DELAY);
  localparam logic [15:0] PERIOD_LOAD = 16'(REPEAT_PERIOD);

  logic [N_BUTTONS-1:0] w_rptPulse;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_repeat
    if (REPEAT_MASK[gi]) begin : g_on
      logic [15:0] r_rptCnt;
      logic        r_rptPulse;

      // Counter is armed on press, cleared on release, and never decremented at zero.
      always_ff @(posedge clk_2M5) begin
        if (rst) begin
          r_rptCnt   <= '0;
          r_rptPulse <= 1'b0;
        end else begin
          r_rptPulse <= 1'b0;
          if (w_toggle[gi] && !r_level[gi]) begin
            r_rptCnt <= DELAY_LOAD;
          end else if (w_toggle[gi] && r_level[gi]) begin
            r_rptCnt <= '0;
          end else if (w_tickRise && r_level[gi] && (r_rptCnt != 16'd0)) begin
            if (r_rptCnt == 16'd1) begin
              r_rptPulse <= 1'b1;
              r_rptCnt   <= PERIOD_LOAD;
            end else begin
              r_rptCnt <= r_rptCnt - 16'd1;
            end
          end
        end
      end

      assign w_rptPulse[gi] = r_rptPulse;
    end else begin : g_off
      assign w_rptPulse[gi] = 1'b0;
    end
  end

  assign btn_step = r_press | w_rptPulse;
`else
  assign btn_step = r_press;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: debounce 3 ticks, repeat 8/4 ticks on button 2 only,
// tick period of 16 clocks. Expected step counts follow whether BUTTON_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module tb_button_conditioner;
  localparam int NB = 6;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REPEAT_ON = 1;
`else
  localparam int REPEAT_ON = 0;
`endif

  logic          clk_2M5 = 1'b0;
  logic          rst;
  logic          tick;
  logic [NB-1:0] buttons_n;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_step;

  int            assertCount = 0;
  int            failCount   = 0;
  int            pressCnt[NB];
  int            stepCnt[NB];
  int            backToBack  = 0;
  int            pressBase;
  int            stepBase;
  int            total;
  logic [NB-1:0] prevPress = '0;
  logic [NB-1:0] prevStep  = '0;

  button_conditioner #(
    .N_BUTTONS     (NB),
    .DEBOUNCE_COUNT(3),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .REPEAT_MASK   (6'b000100)
  ) dut (
    .clk_2M5  (clk_2M5),
    .rst      (rst),
    .tick     (tick),
    .buttons_n(buttons_n),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_step (btn_step)
  );

  always #5 clk_2M5 = ~clk_2M5;

  // Square-wave debounce tick, 8 clocks high and 8 low.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (8) @(negedge clk_2M5);
      tick = ~tick;
    end
  end

  // Pulse counters and back-to-back detector, sampled away from the active edge.
  initial begin
    for (int i = 0; i < NB; i++) begin
      pressCnt[i] = 0;
      stepCnt[i]  = 0;
    end
    forever begin
      @(negedge clk_2M5);
      for (int i = 0; i < NB; i++) begin
        if (btn_press[i]) pressCnt[i]++;
        if (btn_step[i])  stepCnt[i]++;
      end
      if (((btn_press & prevPress) != '0) || ((btn_step & prevStep) != '0)) backToBack++;
      prevPress = btn_press;
      prevStep  = btn_step;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the pins, then return one clock after the nTicks-th following tick rise.
  task automatic applyStimulus(input logic [NB-1:0] pins, input int nTicks);
    buttons_n = pins;
    repeat (nTicks) @(posedge tick);
    @(negedge clk_2M5);
  endtask

  initial begin
    rst       = 1'b1;
    buttons_n = 6'h3F;
    repeat (4) @(negedge clk_2M5);
    checkOutput("resetLevel", btn_level, 0);
    checkOutput("resetPress", btn_press, 0);
    checkOutput("resetStep",  btn_step,  0);
    rst = 1'b0;

    $display("[TB] idle for 100 ticks");
    applyStimulus(6'h3F, 100);
    checkOutput("idleLevel", btn_level, 0);
    total = 0;
    for (int i = 0; i < NB; i++) total += pressCnt[i] + stepCnt[i];
    checkOutput("idlePulses", total, 0);

    $display("[TB] button 0 press, no repeat");
    applyStimulus(6'h3E, 2);
    checkOutput("b0BeforeDebounce", btn_level[0], 0);
    applyStimulus(6'h3E, 1);
    checkOutput("b0Level", btn_level[0], 1);
    checkOutput("b0Press", btn_press[0], 1);
    checkOutput("b0Step",  btn_step[0],  1);
    applyStimulus(6'h3E, 12);
    checkOutput("b0HeldLevel", btn_level[0], 1);
    checkOutput("b0PressCount", pressCnt[0], 1);
    checkOutput("b0StepCount",  stepCnt[0],  1);
    applyStimulus(6'h3F, 4);
    checkOutput("b0Released", btn_level[0], 0);
    checkOutput("b0NoReleasePulse", pressCnt[0], 1);

    $display("[TB] button 1 glitches");
    applyStimulus(6'h3D, 2);
    applyStimulus(6'h3F, 1);
    applyStimulus(6'h3D, 2);
    applyStimulus(6'h3F, 4);
    checkOutput("b1GlitchLevel", btn_level[1], 0);
    checkOutput("b1GlitchPress", pressCnt[1], 0);
    checkOutput("b1GlitchStep",  stepCnt[1],  0);

    $display("[TB] button 2 auto-repeat");
    applyStimulus(6'h3B, 3);
    checkOutput("b2Level", btn_level[2], 1);
    checkOutput("b2Press", btn_press[2], 1);
    checkOutput("b2Step",  btn_step[2],  1);
    applyStimulus(6'h3B, 7);
    checkOutput("b2NoEarlyRepeat", btn_step[2], 0);
    applyStimulus(6'h3B, 1);
    checkOutput("b2FirstRepeat", btn_step[2], REPEAT_ON);
    applyStimulus(6'h3B, 12);
    checkOutput("b2FourthRepeat", btn_step[2], REPEAT_ON);
    applyStimulus(6'h3F, 12);
    checkOutput("b2Released",   btn_level[2], 0);
    checkOutput("b2PressCount", pressCnt[2], 1);
    checkOutput("b2StepCount",  stepCnt[2], (REPEAT_ON != 0) ? 5 : 1);

    $display("[TB] buttons 3 and 4 together");
    applyStimulus(6'h27, 3);
    checkOutput("b34PressTogether", btn_press[4:3], 2'b11);
    checkOutput("b34StepTogether",  btn_step[4:3],  2'b11);
    applyStimulus(6'h27, 1);
    checkOutput("b34PressSingle", btn_press[4:3], 2'b00);
    applyStimulus(6'h3F, 4);
    checkOutput("b34Released", btn_level, 0);

    $display("[TB] reset while button 2 held");
    applyStimulus(6'h3B, 3);
    checkOutput("b2HeldBeforeReset", btn_level[2], 1);
    pressBase = pressCnt[2];
    stepBase  = stepCnt[2];
    rst = 1'b1;
    repeat (2) @(negedge clk_2M5);
    checkOutput("rstMidLevel", btn_level, 0);
    checkOutput("rstMidPress", btn_press, 0);
    rst = 1'b0;
    applyStimulus(6'h3B, 2);
    checkOutput("postRstNotYet", btn_level[2], 0);
    applyStimulus(6'h3B, 1);
    checkOutput("postRstLevel", btn_level[2], 1);
    checkOutput("postRstPress", btn_press[2], 1);
    applyStimulus(6'h3F, 4);
    checkOutput("postRstPressCount", pressCnt[2] - pressBase, 1);
    checkOutput("postRstStepCount",  stepCnt[2] - stepBase,   1);
    checkOutput("postRstReleased",   btn_level[2], 0);

    checkOutput("noBackToBack", backToBack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
